pes_elc_scheduler: RTL and testbench
====================================

Name: pes_elc_scheduler

Overview:
Collects floor calls from 8 buttons and sequences the pes_elevator car with a SCAN (sweep) policy: it holds pending calls, issues one one-hot target floor at a time, waits for the car's arrival pulse, runs a door-dwell period, then picks the next target. It sits between the call buttons and the elevator's request_floor/in_current_floor/complete interface.

Parameters:
NUM_FLOORS, 8, number of floors; width of every one-hot floor vector.
DWELL_CYCLES, 4, clocks the door stays open after arrival (>=1).
DWELL_W, 3, width of the dwell counter; must hold DWELL_CYCLES-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
call_req  input  NUM_FLOORS  per-floor call pulses; multiple bits allowed per cycle.
cur_floor  input  NUM_FLOORS  one-hot car position from elevator.
arrive  input  1  one-cycle pulse from elevator (its complete) when car reaches target.
over_weight  input  1  car overloaded; holds doors open.
target_floor  output  NUM_FLOORS  one-hot target to elevator request_floor; 0 when invalid.
target_valid  output  1  target_floor is meaningful.
dir  output  1  sweep direction: 1 = up, 0 = down.
door_open  output  1  high during DWELL.
pending  output  NUM_FLOORS  registered outstanding calls.
pos_fault  output  1  cur_floor not one-hot (sticky until reset).

Behaviour:
- Reset (async): state IDLE, pending=0, target_floor=0, target_valid=0, dir=1, door_open=0, pos_fault=0, dwell counter=0.
- Call capture: every cycle pending <= pending | call_req, minus any bit cleared that cycle. A call and a clear for the same bit in the same cycle resolve to clear. The exception is a call for cur_floor during DWELL: it reloads the dwell counter and never sets pending.
- States: IDLE, SELECT, MOVE, DWELL.
- IDLE:
  - If the pending bit for cur_floor is set, clear it and go to DWELL.
  - Otherwise, if pending is nonzero, go to SELECT.
  - Otherwise stay in IDLE.
- SELECT (one cycle), SCAN rule:
  - If dir=1, target = lowest pending floor strictly above cur_floor. If there is none, set dir=0 and target = highest pending floor below cur_floor.
  - If dir=0, apply the mirror image of the up rule.
  - Register target_floor, set target_valid=1, go to MOVE.
  - Latency: a call edge N reaches pending at N+1, IDLE moves to SELECT at N+2, and target_valid rises at N+3.
- MOVE:
  - target_valid=1.
  - Retarget: if a pending floor lies strictly between cur_floor and target_floor in the travel direction, target_floor updates to the nearest such floor next cycle. target_valid stays high.
  - On arrive: clear the target's pending bit, drop target_valid and target_floor to 0, load the dwell counter with DWELL_CYCLES-1, go to DWELL.
  - arrive outside MOVE is ignored.
- DWELL:
  - door_open=1. The counter decrements each cycle.
  - over_weight=1 holds the counter at DWELL_CYCLES-1.
  - When the counter is 0 and over_weight=0, go to IDLE. The next SELECT re-evaluates dir.
- Position fault: if cur_floor is not one-hot (zero or multi-hot) in IDLE/SELECT/MOVE, set pos_fault=1, drop target_valid, and go to IDLE. While pos_fault=1 the block stays in IDLE and keeps accumulating pending.
- Reset mid-operation clears all pending calls and outputs immediately.

Optional Feature:
Macro ELC_FIRE_RECALL_EN.
- When defined: adds input fire_recall (1 bit). While it is high:
  - pending is forced to 0 and call_req is ignored.
  - Outside DWELL, target_floor = floor 0, target_valid=1, dir=0, state=MOVE.
  - An arrive at floor 0 goes to DWELL. The door stays open (counter held) until fire_recall deasserts.
  - If fire_recall asserts during DWELL, the dwell completes first, then the recall applies.
- When not defined: the port is absent and there is no recall logic.

Decomposition:
- Shared package pes_elc_pkg holds:
  - NUM_FLOORS default and the FSM state enum (IDLE, SELECT, MOVE, DWELL).
  - A onehot_check function.
  - Floor-index/one-hot conversion functions.
- Sub-module pes_elc_scan_pick (combinational): pending, cur_floor, dir in; next_target, next_dir, found out. It is reused for SELECT and for the MOVE retarget check.

Test Plan:
1. Reset, cur_floor=8'h01, call_req=8'h20 pulse -> pending=8'h20 next cycle; target_floor=8'h20, target_valid=1, dir=1 at the 3rd edge after the call.
2. Car at 8'h01 heading to 8'h80; call_req=8'h08 while cur_floor=8'h04 -> target_floor changes to 8'h08. Arrive -> pending bit 3 cleared, then the next target is 8'h80.
3. cur_floor=8'h10, dir=1, pending=8'h05 -> dir flips to 0, target_floor=8'h04; after arrive, the target becomes 8'h01.
4. Arrive, then over_weight=1 for 10 cycles -> door_open stays high for 10 + DWELL_CYCLES cycles, then IDLE.
5. IDLE at 8'h04, call_req=8'h04 -> DWELL directly, target_valid stays 0. A repeat call during DWELL reloads the counter.
6. cur_floor=8'h03 in MOVE -> pos_fault=1, target_valid=0, state IDLE; only reset clears pos_fault.

Source files
------------

// File: rtl/pes_elc_pkg.sv
// -----------------------------------------------------------------------------
// pes_elc_pkg
// Shared definitions for the pes_elevator call scheduler:
//   - default floor count and the scheduler FSM state encoding
//   - onehot_check      : 1 when a floor vector has exactly one bit set
//   - floor_to_idx      : one-hot floor vector -> floor index (lowest set bit)
//   - idx_to_floor      : floor index -> one-hot floor vector
// Floor vectors are carried in a MAX_FLOORS-wide container so the helpers can
// serve any NUM_FLOORS up to MAX_FLOORS; callers zero-extend on the way in.
// -----------------------------------------------------------------------------
package pes_elc_pkg;

  localparam int ELC_NUM_FLOORS = 8;
  localparam int MAX_FLOORS     = 32;
  localparam int FLOOR_IDX_W    = 5;

  typedef logic [MAX_FLOORS-1:0]  floor_vec_t;
  typedef logic [FLOOR_IDX_W-1:0] floor_idx_t;

  // Scheduler FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_MOVE   = 2'd2;
  localparam logic [1:0] ST_DWELL  = 2'd3;

  function automatic logic onehot_check(input floor_vec_t v);
    return $onehot(v);
  endfunction

  // Lowest set bit wins, so a malformed vector still maps to a legal index.
  function automatic floor_idx_t floor_to_idx(input floor_vec_t v);
    floor_idx_t idx;
    idx = '0;
    for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
      if (v[i]) idx = floor_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic floor_vec_t idx_to_floor(input floor_idx_t idx);
    floor_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pes_elc_scan_pick.sv
// -----------------------------------------------------------------------------
// pes_elc_scan_pick
// Combinational SCAN (sweep) target picker.
//   dir=1: nearest pending floor strictly above cur_floor; if none, reverse and
//          take the nearest pending floor strictly below.
//   dir=0: mirror image.
// Ports:
//   pending     in  outstanding calls (one bit per floor)
//   cur_floor   in  one-hot car position
//   dir         in  current sweep direction (1 = up)
//   next_target out one-hot chosen floor, 0 when nothing found
//   next_dir    out direction after the pick (flips only on reversal)
//   found       out a target was found
// The pending bit of cur_floor itself is never chosen.
// -----------------------------------------------------------------------------
module pes_elc_scan_pick
  import pes_elc_pkg::*;
#(
  parameter int NUM_FLOORS = ELC_NUM_FLOORS
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [NUM_FLOORS-1:0] cur_floor,
  input  logic                  dir,
  output logic [NUM_FLOORS-1:0] next_target,
  output logic                  next_dir,
  output logic                  found
);

  floor_vec_t cur_vec;
  floor_idx_t cur_idx;
  floor_idx_t up_idx;
  floor_idx_t down_idx;
  floor_idx_t tgt_idx;
  logic       up_found;
  logic       down_found;

  always_comb begin
    cur_vec                   = '0;
    cur_vec[NUM_FLOORS-1:0]   = cur_floor;
    cur_idx                   = floor_to_idx(cur_vec);

    // Nearest above: scan downward so the lowest qualifying floor is written last.
    up_found = 1'b0;
    up_idx   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(cur_idx))) begin
        up_found = 1'b1;
        up_idx   = floor_idx_t'(i);
      end
    end

    // Nearest below: scan upward so the highest qualifying floor is written last.
    down_found = 1'b0;
    down_idx   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(cur_idx))) begin
        down_found = 1'b1;
        down_idx   = floor_idx_t'(i);
      end
    end

    found    = 1'b0;
    next_dir = dir;
    tgt_idx  = '0;
    if (dir) begin
      if (up_found) begin
        found   = 1'b1;
        tgt_idx = up_idx;
      end else if (down_found) begin
        found    = 1'b1;
        tgt_idx  = down_idx;
        next_dir = 1'b0;
      end
    end else begin
      if (down_found) begin
        found   = 1'b1;
        tgt_idx = down_idx;
      end else if (up_found) begin
        found    = 1'b1;
        tgt_idx  = up_idx;
        next_dir = 1'b1;
      end
    end

    next_target = found ? NUM_FLOORS'(idx_to_floor(tgt_idx)) : '0;
  end

endmodule

// File: rtl/pes_elc_scheduler.sv
// -----------------------------------------------------------------------------
// pes_elc_scheduler
// Collects floor calls and sequences the pes_elevator car with a SCAN policy:
// IDLE -> SELECT (pick target) -> MOVE (wait for arrive, retarget on the way)
// -> DWELL (door open) -> IDLE.
// Ports:
//   clk           in  system clock, rising edge
//   reset         in  asynchronous active-high reset
//   call_req      in  per-floor call pulses (several bits per cycle allowed)
//   cur_floor     in  one-hot car position
//   arrive        in  one-cycle arrival pulse (elevator complete), MOVE only
//   over_weight   in  holds the door open
//   fire_recall   in  (ELC_FIRE_RECALL_EN only) send the car to floor 0
//   target_floor  out one-hot target, 0 when not valid
//   target_valid  out target_floor is meaningful
//   dir           out sweep direction, 1 = up
//   door_open     out high in DWELL
//   pending       out registered outstanding calls
//   pos_fault     out sticky: cur_floor seen not one-hot outside DWELL
// Optional feature: define ELC_FIRE_RECALL_EN to add the fire_recall input.
// NUM_FLOORS must not exceed pes_elc_pkg::MAX_FLOORS.
// -----------------------------------------------------------------------------
module pes_elc_scheduler
  import pes_elc_pkg::*;
#(
  parameter int NUM_FLOORS   = ELC_NUM_FLOORS,
  parameter int DWELL_CYCLES = 4,
  parameter int DWELL_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [NUM_FLOORS-1:0] cur_floor,
  input  logic                  arrive,
  input  logic                  over_weight,
`ifdef ELC_FIRE_RECALL_EN
  input  logic                  fire_recall,
`endif
  output logic [NUM_FLOORS-1:0] target_floor,
  output logic                  target_valid,
  output logic                  dir,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  pos_fault
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [DWELL_W-1:0]    dwell_cnt;
  logic [DWELL_W-1:0]    dwell_n;
  logic [NUM_FLOORS-1:0] pending_n;
  logic [NUM_FLOORS-1:0] target_n;
  logic                  valid_n;
  logic                  dir_n;
  logic                  pos_fault_n;
  logic [NUM_FLOORS-1:0] call_eff;
  logic [NUM_FLOORS-1:0] clear_mask;
  floor_vec_t            cur_vec;
  logic                  cur_ok;

  logic [NUM_FLOORS-1:0] pick_target;
  logic                  pick_dir;
  logic                  pick_found;
  logic                  retarget;

`ifdef ELC_FIRE_RECALL_EN
  localparam logic [NUM_FLOORS-1:0] FLOOR0 = NUM_FLOORS'(1);
  // Set when the current DWELL was entered by a recall arrival; such a dwell
  // holds the door open for as long as the recall lasts.
  logic recall_dwell;
  logic recall_dwell_n;
`endif

  // One picker serves both SELECT and the MOVE retarget check: in MOVE, a pick
  // in the same direction that is nearer than the current target is exactly a
  // pending floor lying between the car and the target.
  pes_elc_scan_pick #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_scan_pick (
    .pending     (pending),
    .cur_floor   (cur_floor),
    .dir         (dir),
    .next_target (pick_target),
    .next_dir    (pick_dir),
    .found       (pick_found)
  );

  // One-hot vectors compare numerically in floor order.
  assign retarget = pick_found && (pick_dir == dir) &&
                    (dir ? (pick_target < target_floor) : (pick_target > target_floor));

  assign door_open = (state == ST_DWELL);

  always_comb begin
    cur_vec                 = '0;
    cur_vec[NUM_FLOORS-1:0] = cur_floor;
    cur_ok                  = onehot_check(cur_vec);
  end

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n     = state;
    dwell_n     = dwell_cnt;
    target_n    = target_floor;
    valid_n     = target_valid;
    dir_n       = dir;
    pos_fault_n = pos_fault;
    call_eff    = call_req;
    clear_mask  = '0;
`ifdef ELC_FIRE_RECALL_EN
    recall_dwell_n = recall_dwell;
`endif

    case (state)
      ST_IDLE: begin
        if (pos_fault) begin
          state_n = ST_IDLE;
        end else if (!cur_ok) begin
          pos_fault_n = 1'b1;
        end else if (|(pending & cur_floor)) begin
          // Call for the floor the car already sits at: open the door directly.
          clear_mask = cur_floor;
          dwell_n    = DWELL_LOAD;
          state_n    = ST_DWELL;
        end else if (|pending) begin
          state_n = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (!cur_ok) begin
          pos_fault_n = 1'b1;
          valid_n     = 1'b0;
          target_n    = '0;
          state_n     = ST_IDLE;
        end else if (pick_found) begin
          target_n = pick_target;
          valid_n  = 1'b1;
          dir_n    = pick_dir;
          state_n  = ST_MOVE;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_MOVE: begin
        if (!cur_ok) begin
          pos_fault_n = 1'b1;
          valid_n     = 1'b0;
          target_n    = '0;
          state_n     = ST_IDLE;
        end else if (arrive) begin
          clear_mask = target_floor;
          target_n   = '0;
          valid_n    = 1'b0;
          dwell_n    = DWELL_LOAD;
          state_n    = ST_DWELL;
        end else if (retarget) begin
          target_n = pick_target;
        end
      end

      ST_DWELL: begin
        if (|(call_req & cur_floor)) begin
          // A call for the open-door floor extends the dwell instead of
          // queueing a trip to where the car already is.
          call_eff = call_req & ~cur_floor;
          dwell_n  = DWELL_LOAD;
        end else if (over_weight) begin
          dwell_n = DWELL_LOAD;
        end else if (dwell_cnt == '0) begin
          state_n = ST_IDLE;
        end else begin
          dwell_n = dwell_cnt - DWELL_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Clear wins over a same-cycle call for the same floor.
    pending_n = (pending | call_eff) & ~clear_mask;

`ifdef ELC_FIRE_RECALL_EN
    if (fire_recall) begin
      pending_n = '0;
      // With a position fault the car location is unknown; stay parked.
      if (!pos_fault) begin
        if (state == ST_DWELL) begin
          // A normal dwell finishes on its own; a recall dwell stays open.
          if (recall_dwell) begin
            dwell_n = DWELL_LOAD;
            state_n = ST_DWELL;
          end
        end else if ((state == ST_MOVE) && cur_ok && arrive && cur_floor[0] &&
                     (target_floor == FLOOR0)) begin
          target_n       = '0;
          valid_n        = 1'b0;
          dir_n          = 1'b0;
          dwell_n        = DWELL_LOAD;
          state_n        = ST_DWELL;
          recall_dwell_n = 1'b1;
        end else if (cur_ok) begin
          target_n = FLOOR0;
          valid_n  = 1'b1;
          dir_n    = 1'b0;
          state_n  = ST_MOVE;
        end
      end
    end
    if (state_n != ST_DWELL) recall_dwell_n = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      dwell_cnt    <= '0;
      pending      <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      dir          <= 1'b1;
      pos_fault    <= 1'b0;
    end else begin
      state        <= state_n;
      dwell_cnt    <= dwell_n;
      pending      <= pending_n;
      target_floor <= target_n;
      target_valid <= valid_n;
      dir          <= dir_n;
      pos_fault    <= pos_fault_n;
    end
  end

`ifdef ELC_FIRE_RECALL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) recall_dwell <= 1'b0;
    else       recall_dwell <= recall_dwell_n;
  end
`endif

endmodule

// File: tb/tb_pes_elc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pes_elc_scheduler
// Directed bench for pes_elc_scheduler (NUM_FLOORS=8, DWELL_CYCLES=4).
// Every issued target is predicted into a scoreboard queue when the calls are
// driven; a monitor pops and compares whenever target_valid rises or the
// target changes. Directed checks cover reset, latency, dwell timing,
// over_weight hold, same-floor calls and position faults.
// -----------------------------------------------------------------------------
module tb_pes_elc_scheduler;

  localparam int N  = 8;
  localparam int DC = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] call_req;
  logic [N-1:0] cur_floor;
  logic         arrive;
  logic         over_weight;
`ifdef ELC_FIRE_RECALL_EN
  logic         fire_recall;
`endif
  logic [N-1:0] target_floor;
  logic         target_valid;
  logic         dir;
  logic         door_open;
  logic [N-1:0] pending;
  logic         pos_fault;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] sb_q[$];
  logic         mon_prev_valid = 1'b0;
  logic [N-1:0] mon_prev_target = '0;

  pes_elc_scheduler #(
    .NUM_FLOORS   (N),
    .DWELL_CYCLES (DC),
    .DWELL_W      (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .call_req     (call_req),
    .cur_floor    (cur_floor),
    .arrive       (arrive),
    .over_weight  (over_weight),
`ifdef ELC_FIRE_RECALL_EN
    .fire_recall  (fire_recall),
`endif
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir          (dir),
    .door_open    (door_open),
    .pending      (pending),
    .pos_fault    (pos_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!target_valid && n < 30) begin
      step(1);
      n++;
    end
    check(tag, 32'(target_valid), 32'd1);
  endtask

  // Counts cycles the door remains open from now on (bounded).
  task automatic count_door(inout int n);
    int guard;
    guard = 0;
    while (door_open && guard < 100) begin
      n++;
      guard++;
      step(1);
    end
  endtask

  // Scoreboard monitor: each new target issue pops one prediction.
  always @(negedge clk) begin
    logic [N-1:0] exp_t;
    if (target_valid === 1'b1 &&
        (!mon_prev_valid || target_floor !== mon_prev_target)) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow_size", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t = sb_q.pop_front();
        check("sb_target", 32'(target_floor), 32'(exp_t));
      end
    end
    mon_prev_valid  = (target_valid === 1'b1);
    mon_prev_target = target_floor;
  end

  initial begin
    int n;
    reset       = 1'b1;
    call_req    = '0;
    cur_floor   = 8'h01;
    arrive      = 1'b0;
    over_weight = 1'b0;
`ifdef ELC_FIRE_RECALL_EN
    fire_recall = 1'b0;
`endif
    step(2);
    reset = 1'b0;
    step(1);

    // ---- reset state ----
    check("rst_valid",   32'(target_valid), 32'd0);
    check("rst_target",  32'(target_floor), 32'h00);
    check("rst_dir",     32'(dir),          32'd1);
    check("rst_door",    32'(door_open),    32'd0);
    check("rst_pending", 32'(pending),      32'h00);
    check("rst_fault",   32'(pos_fault),    32'd0);

    // ---- 1: call latency ----
    call_req = 8'h20;
    sb_q.push_back(8'h20);
    step(1);
    call_req = '0;
    check("t1_pending_n1", 32'(pending), 32'h20);
    step(1);
    check("t1_valid_n2", 32'(target_valid), 32'd0);
    step(1);
    check("t1_valid_n3",  32'(target_valid), 32'd1);
    check("t1_target_n3", 32'(target_floor), 32'h20);
    check("t1_dir_n3",    32'(dir),          32'd1);
    cur_floor = 8'h20;
    arrive    = 1'b1;
    step(1);
    arrive = 1'b0;
    check("t1_door_arr",    32'(door_open),    32'd1);
    check("t1_valid_arr",   32'(target_valid), 32'd0);
    check("t1_pending_arr", 32'(pending),      32'h00);
    n = 0;
    count_door(n);
    check("t1_dwell_len", 32'(n), 32'(DC));

    // ---- 2: retarget on the way up ----
    cur_floor = 8'h01;
    call_req  = 8'h80;
    sb_q.push_back(8'h80);
    step(1);
    call_req = '0;
    wait_valid("t2_valid_timeout");
    cur_floor = 8'h02;
    step(1);
    cur_floor = 8'h04;
    call_req  = 8'h08;
    sb_q.push_back(8'h08);
    step(1);
    call_req = '0;
    step(1);
    check("t2_retarget", 32'(target_floor), 32'h08);
    check("t2_valid_rt", 32'(target_valid), 32'd1);
    cur_floor = 8'h08;
    arrive    = 1'b1;
    step(1);
    arrive = 1'b0;
    check("t2_pending_clr", 32'(pending), 32'h80);
    sb_q.push_back(8'h80);
    n = 0;
    count_door(n);
    wait_valid("t2_next_timeout");
    check("t2_next_target", 32'(target_floor), 32'h80);
    cur_floor = 8'h80;
    arrive    = 1'b1;
    step(1);
    arrive = 1'b0;
    n = 0;
    count_door(n);

    // ---- 3: direction reversal ----
    cur_floor = 8'h10;
    check("t3_dir_before", 32'(dir), 32'd1);
    call_req = 8'h05;
    sb_q.push_back(8'h04);
    sb_q.push_back(8'h01);
    step(1);
    call_req = '0;
    wait_valid("t3_valid_timeout");
    check("t3_dir_flip", 32'(dir),          32'd0);
    check("t3_target",   32'(target_floor), 32'h04);
    cur_floor = 8'h04;
    arrive    = 1'b1;
    step(1);
    arrive = 1'b0;
    check("t3_pending", 32'(pending), 32'h01);
    n = 0;
    count_door(n);
    check("t3_dwell_len", 32'(n), 32'(DC));
    wait_valid("t3_next_timeout");
    check("t3_next_target", 32'(target_floor), 32'h01);

    // ---- 4: over_weight holds the door ----
    cur_floor = 8'h01;
    arrive    = 1'b1;
    step(1);
    arrive      = 1'b0;
    over_weight = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (door_open) n++;
      step(1);
    end
    over_weight = 1'b0;
    count_door(n);
    check("t4_ow_door_len", 32'(n), 32'(10 + DC));
    check("t4_valid_after", 32'(target_valid), 32'd0);

    // ---- 5: call at the current floor, reload during dwell ----
    cur_floor = 8'h04;
    step(1);
    call_req = 8'h04;
    step(1);
    call_req = '0;
    check("t5_door_n1",    32'(door_open), 32'd0);
    check("t5_pending_n1", 32'(pending),   32'h04);
    step(1);
    check("t5_door_n2",    32'(door_open),    32'd1);
    check("t5_valid_n2",   32'(target_valid), 32'd0);
    check("t5_pending_n2", 32'(pending),      32'h00);
    step(2);
    call_req = 8'h04;
    step(1);
    call_req = '0;
    check("t5_pending_rl", 32'(pending), 32'h00);
    n = 0;
    count_door(n);
    check("t5_reload_len", 32'(n), 32'(DC));

    // ---- 6: position fault ----
    cur_floor = 8'h01;
    call_req  = 8'h40;
    sb_q.push_back(8'h40);
    step(1);
    call_req = '0;
    wait_valid("t6_valid_timeout");
    check("t6_dir", 32'(dir), 32'd1);
    cur_floor = 8'h03;
    step(1);
    check("t6_fault",  32'(pos_fault),    32'd1);
    check("t6_valid",  32'(target_valid), 32'd0);
    check("t6_target", 32'(target_floor), 32'h00);
    call_req = 8'h02;
    step(1);
    call_req = '0;
    step(1);
    check("t6_pending_acc", 32'(pending),   32'h42);
    check("t6_fault_stick", 32'(pos_fault), 32'd1);
    cur_floor = 8'h01;
    step(3);
    check("t6_valid_parked", 32'(target_valid), 32'd0);
    check("t6_door_parked",  32'(door_open),    32'd0);
    check("t6_fault_held",   32'(pos_fault),    32'd1);
    #2;
    reset = 1'b1;
    #2;
    check("t6_rst_fault",   32'(pos_fault), 32'd0);
    check("t6_rst_pending", 32'(pending),   32'h00);
    check("t6_rst_dir",     32'(dir),       32'd1);
    step(1);
    reset = 1'b0;
    step(2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
